// File: rtl/mmu_job_arbiter.sv
// Round-robin arbiter sharing one 2x2 matrix-multiply unit between two host requesters.
// Each job: clear the unit, stream LOAD_BEATS operand bytes in, forward OUT_BEATS result bytes back.
module mmu_job_arbiter #(
  parameter int LOAD_BEATS = 8,
  parameter int OUT_BEATS  = 8,
  parameter int TIMEOUT    = 64,
  parameter int CW         = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] transpose_req,
  input  logic [1:0] in_valid,
  input  logic [7:0] in_data0,
  input  logic [7:0] in_data1,
  output logic [1:0] in_ready,
  output logic [1:0] out_valid,
  output logic [7:0] out_data,
  output logic [1:0] grant,
  output logic       job_done,
  output logic       timeout_err,
  output logic       mmu_clear,
  output logic       mmu_load_en,
  output logic [7:0] mmu_indata,
  output logic       mmu_transpose,
  input  logic       mmu_done,
  input  logic [7:0] mmu_outdata
);

  localparam int MAXB = (LOAD_BEATS > OUT_BEATS) ? LOAD_BEATS : OUT_BEATS;
  localparam int NW   = $clog2(MAXB + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_DRAIN   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_q, rr_d;
  logic [1:0]      grant_q, grant_d;
  logic            transpose_q, transpose_d;
  logic            err_q, err_d;
  logic [NW-1:0]   load_cnt_q, load_cnt_d;
  logic [NW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            owner_sel_s;
  logic [1:0]      owner_oh_s;

  // Both requesting: round-robin pointer decides; otherwise the sole requester wins.
  assign owner_sel_s = (req == 2'b11) ? rr_q : req[1];
  assign owner_oh_s  = owner_q ? 2'b10 : 2'b01;

  assign grant         = grant_q;
  assign mmu_transpose = transpose_q;
  assign timeout_err   = err_q;

  // State and job-context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      grant_q     <= 2'b00;
      transpose_q <= 1'b0;
      err_q       <= 1'b0;
      load_cnt_q  <= '0;
      out_cnt_q   <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      transpose_q <= transpose_d;
      err_q       <= err_d;
      load_cnt_q  <= load_cnt_d;
      out_cnt_q   <= out_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  // Next-state logic and per-state datapath steering.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    transpose_d = transpose_q;
    err_d       = err_q;
    load_cnt_d  = load_cnt_q;
    out_cnt_d   = out_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    in_ready    = 2'b00;
    out_valid   = 2'b00;
    out_data    = 8'h00;
    job_done    = 1'b0;
    mmu_clear   = 1'b0;
    mmu_load_en = 1'b0;
    mmu_indata  = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          owner_d     = owner_sel_s;
          grant_d     = owner_sel_s ? 2'b10 : 2'b01;
          transpose_d = transpose_req[owner_sel_s];
          state_d     = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        mmu_clear = 1'b1;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        in_ready = owner_oh_s;
        if (in_valid[owner_q]) begin
          mmu_load_en = 1'b1;
          mmu_indata  = owner_q ? in_data1 : in_data0;
          load_cnt_d  = load_cnt_q + NW'(1);
          if (load_cnt_q == NW'(LOAD_BEATS - 1)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (mmu_done) begin
          out_valid  = owner_oh_s;
          out_data   = mmu_outdata;
          idle_cnt_d = '0;
          out_cnt_d  = out_cnt_q + NW'(1);
          if (out_cnt_q == NW'(OUT_BEATS - 1)) begin
            state_d = S_RELEASE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
          // TIMEOUT consecutive silent cycles: give up on the unit and free the slot.
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        job_done   = 1'b1;
        grant_d    = 2'b00;
        rr_d       = ~owner_q;
        load_cnt_d = '0;
        out_cnt_d  = '0;
        idle_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/mmu_job_arbiter.md
Name: mmu_job_arbiter

Overview:
- Shares one 2x2 matrix-multiply unit (control unit plus systolic array) between two host requesters.
- Grants one requester at a time, round-robin.
- For the granted requester: clears the unit, streams LOAD_BEATS operand bytes into it, then returns OUT_BEATS result bytes.
- Sits between the two host-side byte channels and the matrix unit's load_en/indata/done/outdata interface.

Parameters:
LOAD_BEATS, 8, operand bytes per job (4 weights + 4 inputs)
OUT_BEATS, 8, result bytes per job (c00..c11, high byte first)
TIMEOUT, 64, max DRAIN cycles without a done beat before forced release
CW, 7, width of timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
req  input  2  per-requester job request (bit i = requester i)
transpose_req  input  2  per-requester transpose option, sampled at grant
in_valid  input  2  per-requester operand byte valid
in_data0  input  8  requester 0 operand byte
in_data1  input  8  requester 1 operand byte
in_ready  output  2  operand byte accepted (one-hot to the granted requester, LOAD only)
out_valid  output  2  result byte valid (one-hot to the granted requester)
out_data  output  8  result byte (shared bus)
grant  output  2  one-hot current owner, 0 when idle
job_done  output  1  one-cycle pulse at job release
timeout_err  output  1  sticky; set on DRAIN timeout; cleared only by rst
mmu_clear  output  1  reset pulse to the matrix unit
mmu_load_en  output  1  load strobe to the matrix unit
mmu_indata  output  8  operand byte to the matrix unit
mmu_transpose  output  1  transpose to the matrix unit
mmu_done  input  1  result byte valid from the matrix unit
mmu_outdata  input  8  result byte from the matrix unit

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, rr_ptr=0 (requester 0 has first priority), counters 0.
  - grant=0, in_ready=0, out_valid=0, job_done=0, timeout_err=0, mmu_clear=0, mmu_load_en=0, mmu_transpose=0.
  - mmu_indata=0, out_data=0.
- Reset mid-job abandons the job; no job_done.
- States: IDLE, CLEAR, LOAD, DRAIN, RELEASE.
- IDLE:
  - If req!=0, pick the owner. Both requesting: owner=rr_ptr. One requesting: owner=that one.
  - Next edge: grant<=one-hot(owner), mmu_transpose<=transpose_req[owner], go to CLEAR.
- CLEAR: mmu_clear=1 for exactly one cycle; go to LOAD.
- LOAD:
  - in_ready[owner]=1 (combinational).
  - Beat = in_valid[owner]&in_ready[owner]. On a beat: mmu_load_en=1, mmu_indata=in_data of owner (combinational pass-through).
  - No beat: mmu_load_en=0, mmu_indata=0.
  - load_cnt increments per beat; the beat with load_cnt==LOAD_BEATS-1 moves to DRAIN.
  - Stalls of any length are legal.
- DRAIN:
  - out_valid[owner]=mmu_done; out_data=mmu_outdata when mmu_done, else 0.
  - out_cnt increments per done beat; the beat with out_cnt==OUT_BEATS-1 moves to RELEASE.
  - Idle counter resets on each done beat. If it reaches TIMEOUT, set timeout_err and go to RELEASE.
  - mmu_load_en=0 throughout.
- RELEASE (1 cycle):
  - job_done=1, grant<=0, rr_ptr<=~owner, counters cleared; go to IDLE.
- Grant changes only in IDLE→CLEAR and RELEASE. req deassertion after grant is ignored; the job runs to completion.
- Non-owner signals are ignored. Non-owner in_ready and out_valid bits stay 0.
- mmu_done outside DRAIN is ignored.
- Minimum job length is 1+1+LOAD_BEATS+OUT_BEATS+1 cycles, plus unit latency. Back-to-back jobs take one IDLE cycle between RELEASE and the next CLEAR.
- Counters: load_cnt and out_cnt are $clog2(max(LOAD_BEATS, OUT_BEATS)+1) bits; the idle counter is CW bits. No wrap occurs within a job.

Test Plan:
- Single job: req=2'b01, 8 operand bytes 1,2,3,4,5,6,7,8 with in_valid continuous → grant=01 one cycle after req; mmu_clear pulses once; mmu_load_en high 8 consecutive cycles carrying 1..8; 8 done beats forwarded on out_valid[0]; job_done pulse; grant returns to 0.
- Contention: req=2'b11 held from reset → requester 0 served first, then requester 1, then requester 0 again; rr_ptr alternates; grant never has two bits set.
- Stall: in_valid[0] toggles 1,0,0,1,... → mmu_load_en tracks each accepted beat only; exactly 8 load strobes; LOAD exits on the 8th beat.
- Timeout: mmu_done held 0 in DRAIN → after TIMEOUT=64 cycles, timeout_err=1, job_done pulses, grant released; timeout_err stays 1 through a following successful job.
- Isolation: during requester 1's job, in_valid[0]=1 with in_data0=8'hFF and mmu_done asserted during LOAD → in_ready[0]=0 and out_valid[0]=0; mmu_indata never 8'hFF; no spurious out_cnt increment.
- Async reset in DRAIN after 3 result beats → all outputs 0 immediately, no job_done; the next req=2'b10 gets a fresh job starting with a mmu_clear pulse.
